seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Programmable serial bit-pattern detector: parametrised successor of the fixed 4-bit detector FSM.
//  Compares a qualified serial bit stream against a runtime-loaded PAT_W-bit pattern.
//  Selects overlapping or non-overlapping match mode and counts matches.
//  Sits behind serial front-ends (UART/SPI deserialisers) as a frame-sync / marker finder.
// PARAMETERS
//  PAT_W    4     pattern length in bits (2..32)
//  CNT_W    8     match counter width
//  PAT_RST  4'b1001  pattern value after reset (PAT_W bits)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      detector enable; 0 forces IDLE and clears history
//  cfg_load   in   1      latch cfg_pattern/cfg_overlap this cycle
//  cfg_pattern in  PAT_W  pattern; bit PAT_W-1 = oldest (first-received) bit
//  cfg_overlap in  1      1 = overlapping matches, 0 = non-overlapping
//  in_valid   in   1      in_bit qualifier
//  in_bit     in   1      serial data bit
//  match      out  1      one-cycle pulse, registered
//  match_cnt  out  CNT_W  saturating match count
//  busy       out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, history=0, fill=0, pattern=PAT_RST, overlap=1, match=0, match_cnt=0.
//  History: PAT_W-bit shift register; on accepted bit: hist <= {hist[PAT_W-2:0], in_bit}.
//  fill counter: $clog2(PAT_W+1) bits, counts accepted bits, saturates at PAT_W.
//  Accepted bit = in_valid & en & !cfg_load & state!=IDLE.
//  FSM states (enum in package):
//   IDLE   : en=0. Next FILL when en=1. history/fill held at 0.
//   FILL   : fill<PAT_W. Next DETECT when accepted bit makes fill==PAT_W.
//   DETECT : window full. Compare every accepted bit.
//  Any state with en=0 -> IDLE next cycle; history and fill cleared.
//  Match condition: accepted bit completing window (new fill==PAT_W) and new hist == pattern.
//  match asserted the cycle after the completing bit (latency 1), high for exactly 1 cycle.
//  On match: overlap=1 -> stay DETECT, history kept.
//  On match: overlap=0 -> fill<=0, hist<=0, go FILL (next match needs PAT_W fresh bits).
//  match_cnt increments on each match, saturates at all-ones, cleared only by rst.
//  cfg_load: pattern/overlap latched; history and fill cleared; state -> FILL if en else IDLE.
//  cfg_load with in_valid in the same cycle: load wins, bit discarded, no match possible that cycle.
//  in_valid=0: no shift, no compare, match=0; gaps between bits allowed arbitrarily.
//  rst mid-stream: all state to reset values immediately (async), match drops same instant.
// CONFIGURATION
//  MATCH_MASK_EN defined: adds input cfg_mask[PAT_W-1:0], latched with cfg_load (reset all-ones).
//   Mask bit 0 = don't-care. Match = ((hist ^ pattern) & mask) == 0.
//  MATCH_MASK_EN undefined: no cfg_mask port; exact compare hist == pattern.
// STRUCTURE
//  Package seq_det_pkg: state_e typedef {IDLE, FILL, DETECT}, mode constants OVL_ON/OVL_OFF.
//  Sub-module seq_shift_hist: PAT_W shift register + saturating fill counter, with clear/shift ports.
//  Top holds FSM, config registers, comparator, match/counter registers.
// TESTING
//  1 Defaults, en=1, overlap=1, bits 1,0,0,1,0,0,1 -> match pulses after bits 4 and 7; match_cnt=2.
//  2 cfg_overlap=0 load, same stream -> single match after bit 4; match_cnt=1.
//  3 PAT_W=8, pattern 8'hA5, stream 0xA5 with in_valid gaps -> one match 1 cycle after last bit.
//  4 cfg_load same cycle as 4th bit of 1001 -> no match; next 1001 -> match.
//  5 CNT_W=2, 5 overlapping matches -> match_cnt sticks at 3; en drop mid-pattern -> no match, busy=0.
//  6 MATCH_MASK_EN: pattern 1001, mask 1001, stream 1111 -> match; rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional don't-care masking is enabled by defining MATCH_MASK_EN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_e;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    // Masked equality on zero-extended operands; a 0 mask bit ignores that position.
    function automatic logic masked_eq(
        input logic [PAT_W_MAX-1:0] a,
        input logic [PAT_W_MAX-1:0] b,
        input logic [PAT_W_MAX-1:0] mask
    );
        return (((a ^ b) & mask) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// Configuration, serial input and result signals of seq_detector_prog.
// cfg_mask exists only when MATCH_MASK_EN is defined.
interface seq_detector_prog_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
`ifdef MATCH_MASK_EN
    logic [PAT_W-1:0] cfg_mask;
`endif
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

`ifdef MATCH_MASK_EN
    modport master (
        output en, cfg_load, cfg_pattern, cfg_overlap, cfg_mask, in_valid, in_bit,
        input  match, match_cnt, busy
    );
    modport slave (
        input  en, cfg_load, cfg_pattern, cfg_overlap, cfg_mask, in_valid, in_bit,
        output match, match_cnt, busy
    );
`else
    modport master (
        output en, cfg_load, cfg_pattern, cfg_overlap, in_valid, in_bit,
        input  match, match_cnt, busy
    );
    modport slave (
        input  en, cfg_load, cfg_pattern, cfg_overlap, in_valid, in_bit,
        output match, match_cnt, busy
    );
`endif

endinterface

// File: rtl/seq_shift_hist.sv
// History shift register plus saturating fill counter; exposes the
// post-shift values so the caller can compare before they are registered.
module seq_shift_hist #(
    parameter int PAT_W  = 4,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic              bit_in,
    output logic [PAT_W-1:0]  hist,
    output logic [FILL_W-1:0] fill,
    output logic [PAT_W-1:0]  hist_nxt,
    output logic [FILL_W-1:0] fill_nxt
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;

    // Values the registers would take if the current bit is shifted in.
    always_comb begin
        hist_nxt_s = {hist_r[PAT_W-2:0], bit_in};
        if (fill_r == FILL_MAX) begin
            fill_nxt_s = FILL_MAX;
        end else begin
            fill_nxt_s = fill_r + FILL_W'(1'b1);
        end
    end

    // History and fill registers; clear has priority over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (clear) begin
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (shift) begin
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    assign hist     = hist_r;
    assign fill     = fill_r;
    assign hist_nxt = hist_nxt_s;
    assign fill_nxt = fill_nxt_s;

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector with overlap control and a
// saturating match counter. Define MATCH_MASK_EN to add per-bit don't-care masking.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001)
) (
    input logic                clk,
    input logic                rst,
    seq_detector_prog_if.slave bus
);

    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [PAT_W-1:0]  pat_r;
    logic              ovl_r;
    logic [PAT_W-1:0]  mask_s;
    logic              match_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;

    logic              acc_s;
    logic              hit_s;
    logic              clear_s;
    logic              shift_s;
    logic [PAT_W-1:0]  hist_s;
    logic [FILL_W-1:0] fill_s;
    logic [PAT_W-1:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_nxt_s;

`ifdef MATCH_MASK_EN
    logic [PAT_W-1:0] mask_r;

    // Don't-care mask, latched together with the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r <= {PAT_W{1'b1}};
        end else if (bus.cfg_load) begin
            mask_r <= bus.cfg_mask;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign mask_s = mask_r;
`else
    assign mask_s = {PAT_W{1'b1}};
`endif

    seq_shift_hist #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .shift    (shift_s),
        .bit_in   (bus.in_bit),
        .hist     (hist_s),
        .fill     (fill_s),
        .hist_nxt (hist_nxt_s),
        .fill_nxt (fill_nxt_s)
    );

    // A load in the same cycle as a valid bit discards the bit.
    always_comb begin
        acc_s   = bus.in_valid & bus.en & ~bus.cfg_load & (state_r != IDLE);
        hit_s   = acc_s & (fill_nxt_s == FILL_MAX)
                & masked_eq(32'(hist_nxt_s), 32'(pat_r), 32'(mask_s));
        clear_s = ~bus.en | bus.cfg_load | (hit_s & (ovl_r == OVL_OFF));
        shift_s = acc_s & ~clear_s;
    end

    // Next-state logic; a non-overlapping match restarts the window fill.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.en) begin
            state_nxt_s = IDLE;
        end else if (bus.cfg_load) begin
            state_nxt_s = FILL;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = FILL;
                end
                FILL: begin
                    if (hit_s && (ovl_r == OVL_OFF)) begin
                        state_nxt_s = FILL;
                    end else if (acc_s && (fill_nxt_s == FILL_MAX)) begin
                        state_nxt_s = DETECT;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end
                DETECT: begin
                    if (hit_s && (ovl_r == OVL_OFF)) begin
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = DETECT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Pattern and overlap mode configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= PAT_RST;
            ovl_r <= OVL_ON;
        end else if (bus.cfg_load) begin
            pat_r <= bus.cfg_pattern;
            ovl_r <= bus.cfg_overlap;
        end else begin
            pat_r <= pat_r;
            ovl_r <= ovl_r;
        end
    end

    // One-cycle match pulse and saturating match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            match_r <= hit_s;
            if (hit_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.match     = match_r;
    assign bus.match_cnt = cnt_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: three instances cover the default
// 4-bit build, an 8-bit pattern and a 2-bit saturating counter.
module tb_seq_detector_prog;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_detector_prog_if #(.PAT_W(4), .CNT_W(8)) ia ();
    seq_detector_prog_if #(.PAT_W(8), .CNT_W(8)) ib ();
    seq_detector_prog_if #(.PAT_W(4), .CNT_W(2)) ic ();

    seq_detector_prog #(.PAT_W(4), .CNT_W(8)) ua (.clk(clk), .rst(rst), .bus(ia.slave));
    seq_detector_prog #(.PAT_W(8), .CNT_W(8), .PAT_RST(8'h00)) ub (.clk(clk), .rst(rst), .bus(ib.slave));
    seq_detector_prog #(.PAT_W(4), .CNT_W(2)) uc (.clk(clk), .rst(rst), .bus(ic.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic a_bit(input logic b);
        ia.in_valid = 1'b1;
        ia.in_bit   = b;
        step();
        ia.in_valid = 1'b0;
    endtask

    task automatic b_bit(input logic b);
        ib.in_valid = 1'b1;
        ib.in_bit   = b;
        step();
        ib.in_valid = 1'b0;
    endtask

    task automatic c_bit(input logic b);
        ic.in_valid = 1'b1;
        ic.in_bit   = b;
        step();
        ic.in_valid = 1'b0;
    endtask

    initial begin
        logic [6:0]  s1;
        logic [6:0]  e1;
        logic [6:0]  e2;
        logic [3:0]  s4;
        logic [3:0]  e4;
        logic [7:0]  s3;
        logic [15:0] s5;

        ia.en = 1'b0; ia.cfg_load = 1'b0; ia.cfg_pattern = 4'h0; ia.cfg_overlap = 1'b1;
        ia.in_valid = 1'b0; ia.in_bit = 1'b0;
        ib.en = 1'b0; ib.cfg_load = 1'b0; ib.cfg_pattern = 8'h00; ib.cfg_overlap = 1'b1;
        ib.in_valid = 1'b0; ib.in_bit = 1'b0;
        ic.en = 1'b0; ic.cfg_load = 1'b0; ic.cfg_pattern = 4'h0; ic.cfg_overlap = 1'b1;
        ic.in_valid = 1'b0; ic.in_bit = 1'b0;
`ifdef MATCH_MASK_EN
        ia.cfg_mask = 4'hF; ib.cfg_mask = 8'hFF; ic.cfg_mask = 4'hF;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_match", 32'(ia.match), 32'd0);
        check("rst_cnt", 32'(ia.match_cnt), 32'd0);
        check("rst_busy", 32'(ia.busy), 32'd0);

        // Test 1: default pattern 1001, overlapping.
        ia.en = 1'b1;
        step();
        check("t1_busy", 32'(ia.busy), 32'd1);
        s1 = 7'b1001001;
        e1 = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            a_bit(s1[i]);
            check("t1_match", 32'(ia.match), 32'(e1[i]));
        end
        check("t1_cnt", 32'(ia.match_cnt), 32'd2);
        step();
        check("t1_pulse_drop", 32'(ia.match), 32'd0);

        // Test 2: non-overlapping mode.
        pulse_reset();
        ia.en = 1'b1; ia.cfg_load = 1'b1; ia.cfg_pattern = 4'b1001; ia.cfg_overlap = 1'b0;
        step();
        ia.cfg_load = 1'b0;
        e2 = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            a_bit(s1[i]);
            check("t2_match", 32'(ia.match), 32'(e2[i]));
        end
        check("t2_cnt", 32'(ia.match_cnt), 32'd1);

        // Test 4: load collides with the completing bit.
        pulse_reset();
        ia.en = 1'b1;
        step();
        a_bit(1'b1); a_bit(1'b0); a_bit(1'b0);
        ia.cfg_load = 1'b1; ia.cfg_pattern = 4'b1001; ia.cfg_overlap = 1'b1;
        ia.in_valid = 1'b1; ia.in_bit = 1'b1;
        step();
        ia.cfg_load = 1'b0; ia.in_valid = 1'b0;
        check("t4_load_nomatch", 32'(ia.match), 32'd0);
        step();
        check("t4_load_nomatch2", 32'(ia.match), 32'd0);
        s4 = 4'b1001;
        e4 = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            a_bit(s4[i]);
            check("t4_match", 32'(ia.match), 32'(e4[i]));
        end
        check("t4_cnt", 32'(ia.match_cnt), 32'd1);

        // Test 3: 8-bit pattern A5 with idle gaps between bits.
        ib.en = 1'b1; ib.cfg_load = 1'b1; ib.cfg_pattern = 8'hA5; ib.cfg_overlap = 1'b1;
        step();
        ib.cfg_load = 1'b0;
        s3 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            b_bit(s3[i]);
            check("t3_match", 32'(ib.match), (i == 0) ? 32'd1 : 32'd0);
            for (int g = 0; g <= (i % 3); g++) begin
                step();
                check("t3_gap", 32'(ib.match), 32'd0);
            end
        end
        check("t3_cnt", 32'(ib.match_cnt), 32'd1);

        // Test 5: counter saturation, then enable drop mid-pattern.
        ic.en = 1'b1;
        step();
        s5 = 16'b1001001001001001;
        for (int k = 0; k < 16; k++) begin
            c_bit(s5[15-k]);
            check("t5_match", 32'(ic.match), (k >= 3 && (k % 3) == 0) ? 32'd1 : 32'd0);
        end
        check("t5_cnt_sat", 32'(ic.match_cnt), 32'd3);
        c_bit(1'b0);
        c_bit(1'b0);
        ic.en = 1'b0;
        step();
        check("t5_busy_off", 32'(ic.busy), 32'd0);
        check("t5_match_off", 32'(ic.match), 32'd0);
        ic.en = 1'b1;
        step();
        check("t5_busy_on", 32'(ic.busy), 32'd1);
        c_bit(1'b1);
        check("t5_hist_cleared", 32'(ic.match), 32'd0);
        check("t5_cnt_hold", 32'(ic.match_cnt), 32'd3);

        // Test 6: masked compare (when built in), then asynchronous reset while match is high.
        pulse_reset();
        ia.en = 1'b1;
`ifdef MATCH_MASK_EN
        ia.cfg_load = 1'b1; ia.cfg_pattern = 4'b1001; ia.cfg_mask = 4'b1001; ia.cfg_overlap = 1'b1;
        step();
        ia.cfg_load = 1'b0;
        s4 = 4'b1111;
`else
        step();
        s4 = 4'b1001;
`endif
        for (int i = 3; i >= 0; i--) begin
            a_bit(s4[i]);
            check("t6_match", 32'(ia.match), 32'(e4[i]));
        end
        check("t6_cnt", 32'(ia.match_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_match", 32'(ia.match), 32'd0);
        check("t6_rst_cnt", 32'(ia.match_cnt), 32'd0);
        check("t6_rst_busy", 32'(ia.busy), 32'd0);
        step();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
